// File: rtl/gpio_ctrl_param_if.sv
// Register-bus bundle between the peripheral bus master and the GPIO controller.
interface gpio_ctrl_param_if;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    logic              reg_cs;
    logic              reg_wr;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic [BE_W-1:0]   reg_be;
    logic [DATA_W-1:0] reg_rdata;
    logic              reg_ack;

    modport master (
        output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
        input  reg_rdata, reg_ack
    );

    modport slave (
        input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
        output reg_rdata, reg_ack
    );
endinterface

// File: rtl/gpio_ctrl_param.sv
// Parametrised GPIO controller: synchronised and deglitched pad inputs, atomic
// output updates, and edge/level interrupts behind a simple register bus.
module gpio_ctrl_param #(
    parameter int unsigned NUM_GPIO = 32,
    parameter int unsigned DG_DEPTH = 3
) (
    input  logic                mclk,
    input  logic                h_reset_n,
    input  logic                pulse_1us,
    gpio_ctrl_param_if.slave    bus,
    input  logic [NUM_GPIO-1:0] pad_gpio_in,
    output logic [NUM_GPIO-1:0] pad_gpio_out,
    output logic [NUM_GPIO-1:0] cfg_gpio_dir_sel,
    output logic [NUM_GPIO-1:0] gpio_intr,
    output logic                gpio_irq
);
    localparam int unsigned DATA_W = 32;

    localparam logic [3:0] A_DIR      = 4'd0;
    localparam logic [3:0] A_OUT      = 4'd1;
    localparam logic [3:0] A_IN       = 4'd2;
    localparam logic [3:0] A_OUT_SET  = 4'd3;
    localparam logic [3:0] A_OUT_CLR  = 4'd4;
    localparam logic [3:0] A_OUT_TGL  = 4'd5;
    localparam logic [3:0] A_INT_RISE = 4'd6;
    localparam logic [3:0] A_INT_FALL = 4'd7;
    localparam logic [3:0] A_INT_HIGH = 4'd8;
    localparam logic [3:0] A_INT_LOW  = 4'd9;
    localparam logic [3:0] A_INT_STAT = 4'd10;
    localparam logic [3:0] A_INT_MASK = 4'd11;
    localparam logic [3:0] A_DG_CTRL  = 4'd12;

    logic [NUM_GPIO-1:0] dir_q;
    logic [NUM_GPIO-1:0] out_q;
    logic [NUM_GPIO-1:0] rise_en_q;
    logic [NUM_GPIO-1:0] fall_en_q;
    logic [NUM_GPIO-1:0] high_en_q;
    logic [NUM_GPIO-1:0] low_en_q;
    logic [NUM_GPIO-1:0] stat_q;
    logic [NUM_GPIO-1:0] mask_q;
    logic                dg_mode_q;

    logic [NUM_GPIO-1:0]               sync1_q;
    logic [NUM_GPIO-1:0]               sync2_q;
    logic [NUM_GPIO-1:0][DG_DEPTH-1:0] hist_q;
    logic [NUM_GPIO-1:0]               filt_q;
    logic [NUM_GPIO-1:0]               prev_q;

    logic              ack_q;
    logic [DATA_W-1:0] rdata_q;

    logic                access;
    logic                wr_stb;
    logic                tick;
    logic [DATA_W-1:0]   be_bits;
    logic [NUM_GPIO-1:0] wmask;
    logic [NUM_GPIO-1:0] wbits;
    logic [NUM_GPIO-1:0] filt_nxt;
    logic [NUM_GPIO-1:0] rise;
    logic [NUM_GPIO-1:0] fall;
    logic [NUM_GPIO-1:0] evt;
    logic [NUM_GPIO-1:0] stat_clr;
    logic [DATA_W-1:0]   rd_mux;

    // Access decode, byte-lane masking and sample tick selection.
    always_comb begin
        access  = bus.reg_cs & ~ack_q;
        wr_stb  = access & bus.reg_wr;
        tick    = dg_mode_q | pulse_1us;
        be_bits = {{8{bus.reg_be[3]}}, {8{bus.reg_be[2]}},
                   {8{bus.reg_be[1]}}, {8{bus.reg_be[0]}}};
        wmask   = be_bits[NUM_GPIO-1:0];
        wbits   = bus.reg_wdata[NUM_GPIO-1:0] & wmask;
    end

    // Filter output moves only when the whole sample window agrees.
    always_comb begin
        filt_nxt = filt_q;
        for (int i = 0; i < NUM_GPIO; i++) begin
            if (&hist_q[i]) begin
                filt_nxt[i] = 1'b1;
            end else if (~|hist_q[i]) begin
                filt_nxt[i] = 1'b0;
            end
        end
    end

    // Events are suppressed on pins driven as outputs.
    always_comb begin
        rise     = filt_q & ~prev_q;
        fall     = ~filt_q & prev_q;
        evt      = ((rise & rise_en_q) | (fall & fall_en_q) |
                    (filt_q & high_en_q) | (~filt_q & low_en_q)) & ~dir_q;
        stat_clr = (wr_stb && bus.reg_addr == A_INT_STAT) ? wbits : '0;
    end

    always_comb begin
        rd_mux = '0;
        case (bus.reg_addr)
            A_DIR:      rd_mux = DATA_W'(dir_q);
            A_OUT:      rd_mux = DATA_W'(out_q);
            A_IN:       rd_mux = DATA_W'(filt_q);
            A_INT_RISE: rd_mux = DATA_W'(rise_en_q);
            A_INT_FALL: rd_mux = DATA_W'(fall_en_q);
            A_INT_HIGH: rd_mux = DATA_W'(high_en_q);
            A_INT_LOW:  rd_mux = DATA_W'(low_en_q);
            A_INT_STAT: rd_mux = DATA_W'(stat_q);
            A_INT_MASK: rd_mux = DATA_W'(mask_q);
            A_DG_CTRL:  rd_mux = DATA_W'(dg_mode_q);
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (!h_reset_n) begin
            dir_q     <= '0;
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            high_en_q <= '0;
            low_en_q  <= '0;
            stat_q    <= '0;
            mask_q    <= '0;
            dg_mode_q <= 1'b0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            hist_q    <= '0;
            filt_q    <= '0;
            prev_q    <= '0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            sync1_q <= pad_gpio_in;
            sync2_q <= sync1_q;
            if (tick) begin
                for (int i = 0; i < NUM_GPIO; i++) begin
                    hist_q[i] <= {hist_q[i][DG_DEPTH-2:0], sync2_q[i]};
                end
            end
            filt_q  <= filt_nxt;
            prev_q  <= filt_q;
            ack_q   <= access;
            rdata_q <= (access && !bus.reg_wr) ? rd_mux : '0;
            // Set has priority over a simultaneous write-1-to-clear.
            stat_q  <= (stat_q & ~stat_clr) | evt;
            if (wr_stb) begin
                case (bus.reg_addr)
                    A_DIR:      dir_q     <= (dir_q & ~wmask) | wbits;
                    A_OUT:      out_q     <= (out_q & ~wmask) | wbits;
                    A_OUT_SET:  out_q     <= out_q | wbits;
                    A_OUT_CLR:  out_q     <= out_q & ~wbits;
                    A_OUT_TGL:  out_q     <= out_q ^ wbits;
                    A_INT_RISE: rise_en_q <= (rise_en_q & ~wmask) | wbits;
                    A_INT_FALL: fall_en_q <= (fall_en_q & ~wmask) | wbits;
                    A_INT_HIGH: high_en_q <= (high_en_q & ~wmask) | wbits;
                    A_INT_LOW:  low_en_q  <= (low_en_q & ~wmask) | wbits;
                    A_INT_MASK: mask_q    <= (mask_q & ~wmask) | wbits;
                    A_DG_CTRL: begin
                        if (bus.reg_be[0]) dg_mode_q <= bus.reg_wdata[0];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.reg_ack      = ack_q;
    assign bus.reg_rdata    = rdata_q;
    assign pad_gpio_out     = out_q;
    assign cfg_gpio_dir_sel = dir_q;
    assign gpio_intr        = stat_q & mask_q;
    assign gpio_irq         = |gpio_intr;

endmodule

// File: tb/tb_gpio_ctrl_param.sv
// Self-checking bench for gpio_ctrl_param: a 32-pin and an 8-pin instance
// driven through the register bus and checked against a behavioural model.
`timescale 1ns/1ps
module tb_gpio_ctrl_param;
    localparam int unsigned DG = 3;

    logic        mclk = 1'b0;
    logic        h_reset_n;
    logic        pulse_1us = 1'b0;
    int          tick_cnt = 0;
    logic [31:0] pad32;
    logic [7:0]  pad8;
    logic [31:0] out32, dir32, intr32;
    logic        irq32;
    logic [7:0]  out8, dir8, intr8;
    logic        irq8;

    int n_checks = 0;
    int n_fail   = 0;
    int bus_errors = 0;

    gpio_ctrl_param_if b32 ();
    gpio_ctrl_param_if b8 ();

    gpio_ctrl_param #(.NUM_GPIO(32), .DG_DEPTH(DG)) dut (
        .mclk(mclk), .h_reset_n(h_reset_n), .pulse_1us(pulse_1us), .bus(b32.slave),
        .pad_gpio_in(pad32), .pad_gpio_out(out32), .cfg_gpio_dir_sel(dir32),
        .gpio_intr(intr32), .gpio_irq(irq32)
    );

    gpio_ctrl_param #(.NUM_GPIO(8), .DG_DEPTH(DG)) dut8 (
        .mclk(mclk), .h_reset_n(h_reset_n), .pulse_1us(pulse_1us), .bus(b8.slave),
        .pad_gpio_in(pad8), .pad_gpio_out(out8), .cfg_gpio_dir_sel(dir8),
        .gpio_intr(intr8), .gpio_irq(irq8)
    );

    always #5 mclk = ~mclk;

    // 1us strobe scaled to one pulse every 10 mclk cycles.
    always @(posedge mclk) begin
        if (tick_cnt == 9) begin
            tick_cnt  <= 0;
            pulse_1us <= 1'b1;
        end else begin
            tick_cnt  <= tick_cnt + 1;
            pulse_1us <= 1'b0;
        end
    end

    task automatic bus_xfer(input bit sel8, input bit wr, input logic [3:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be,
                            output logic [31:0] rdata);
        logic ack;
        if (sel8) begin
            b8.reg_cs = 1'b1; b8.reg_wr = wr; b8.reg_addr = addr;
            b8.reg_wdata = wdata; b8.reg_be = be;
        end else begin
            b32.reg_cs = 1'b1; b32.reg_wr = wr; b32.reg_addr = addr;
            b32.reg_wdata = wdata; b32.reg_be = be;
        end
        @(posedge mclk); #1;
        if (sel8) begin
            ack = b8.reg_ack; rdata = b8.reg_rdata; b8.reg_cs = 1'b0;
        end else begin
            ack = b32.reg_ack; rdata = b32.reg_rdata; b32.reg_cs = 1'b0;
        end
        if (ack !== 1'b1) bus_errors++;
        @(posedge mclk); #1;
    endtask

    task automatic wr32(input logic [3:0] addr, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] dummy;
        bus_xfer(1'b0, 1'b1, addr, d, be, dummy);
    endtask

    task automatic rd32(input logic [3:0] addr, output logic [31:0] d);
        bus_xfer(1'b0, 1'b0, addr, 32'h0, 4'h0, d);
    endtask

    task automatic wr8(input logic [3:0] addr, input logic [31:0] d);
        logic [31:0] dummy;
        bus_xfer(1'b1, 1'b1, addr, d, 4'hF, dummy);
    endtask

    task automatic rd8(input logic [3:0] addr, output logic [31:0] d);
        bus_xfer(1'b1, 1'b0, addr, 32'h0, 4'h0, d);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic do_reset;
        h_reset_n = 1'b0;
        pad32 = '0;
        pad8  = '0;
        repeat (2) @(posedge mclk);
        #1;
        h_reset_n = 1'b1;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        do_reset();
        for (int a = 0; a < 16; a++) begin
            rd32(4'(a), d);
            n_checks++;
            if (d !== 32'h0) begin
                n_fail++; $display("FAIL reset_read addr %0d: got %h expected 0", a, d);
            end
        end
        n_checks++;
        if (out32 !== 32'h0 || dir32 !== 32'h0 || irq32 !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: out %h dir %h irq %b expected 0", out32, dir32, irq32);
        end
        // Reset asserted together with a bus request: no ack, state cleared.
        wr32(4'd0, 32'h55, 4'hF);
        wr32(4'd1, 32'hAA, 4'hF);
        b32.reg_cs = 1'b1; b32.reg_wr = 1'b0; b32.reg_addr = 4'd0;
        h_reset_n = 1'b0;
        @(posedge mclk); #1;
        n_checks++;
        if (b32.reg_ack !== 1'b0 || b32.reg_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_inflight: ack %b rdata %h expected 0/0", b32.reg_ack, b32.reg_rdata);
        end
        b32.reg_cs = 1'b0;
        @(posedge mclk); #1;
        h_reset_n = 1'b1;
        rd32(4'd0, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL reset_inflight_dir: got %h expected 0", d);
        end
        rd32(4'd1, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL reset_inflight_out: got %h expected 0", d);
        end
    endtask

    task automatic test_back_to_back;
        logic exp_ack;
        do_reset();
        wr32(4'd0, 32'h1234_5678, 4'hF);
        b32.reg_cs = 1'b1; b32.reg_wr = 1'b0; b32.reg_addr = 4'd0;
        n_checks++;
        if (b32.reg_ack !== 1'b0 || b32.reg_rdata !== 32'h0) begin
            n_fail++; $display("FAIL b2b_idle: ack %b rdata %h expected 0/0", b32.reg_ack, b32.reg_rdata);
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge mclk); #1;
            exp_ack = (c % 2 == 0);
            n_checks++;
            if (b32.reg_ack !== exp_ack || b32.reg_rdata !== (exp_ack ? 32'h1234_5678 : 32'h0)) begin
                n_fail++; $display("FAIL b2b_cycle%0d: ack %b rdata %h expected ack %b", c, b32.reg_ack, b32.reg_rdata, exp_ack);
            end
        end
        b32.reg_cs = 1'b0;
        wait_cyc(1);
    endtask

    task automatic test_out_atomic;
        logic [31:0] d;
        do_reset();
        wr32(4'd1, 32'h0000_00F0, 4'hF);
        wr32(4'd3, 32'h0000_000F, 4'hF);
        wr32(4'd4, 32'h0000_0030, 4'hF);
        wr32(4'd5, 32'h0000_0101, 4'hF);
        rd32(4'd1, d);
        n_checks++;
        if (d !== 32'h0000_01CE || out32 !== 32'h0000_01CE) begin
            n_fail++; $display("FAIL out_atomic: read %h pad %h expected 000001ce", d, out32);
        end
        rd32(4'd3, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL wo_reads_zero: got %h expected 0", d);
        end
        wr32(4'd1, 32'h0, 4'hF);
        wr32(4'd1, 32'hFFFF_FFFF, 4'b0001);
        rd32(4'd1, d);
        n_checks++;
        if (d !== 32'h0000_00FF) begin
            n_fail++; $display("FAIL out_byte_enable: got %h expected 000000ff", d);
        end
    endtask

    task automatic test_deglitch;
        logic [31:0] d;
        do_reset();
        wr32(4'd12, 32'h1, 4'hF);
        pad32[5] = 1'b1;
        wait_cyc(2);
        pad32[5] = 1'b0;
        wait_cyc(8);
        rd32(4'd2, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL dg_short_pulse: got %h expected 0", d);
        end
        // Ten-cycle pulse: IN updates on the 6th edge after the pad change.
        pad32[5] = 1'b1;
        wait_cyc(4);
        rd32(4'd2, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL dg_latency_early: got %h expected 0", d);
        end
        rd32(4'd2, d);
        n_checks++;
        if (d !== 32'h20) begin
            n_fail++; $display("FAIL dg_latency_pass: got %h expected 20", d);
        end
        wait_cyc(2);
        pad32[5] = 1'b0;
        wait_cyc(10);
        rd32(4'd2, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL dg_fall: got %h expected 0", d);
        end
        // Slow mode: a 2us pulse yields two samples and is rejected.
        wr32(4'd12, 32'h0, 4'hF);
        pad32[5] = 1'b1;
        wait_cyc(20);
        pad32[5] = 1'b0;
        wait_cyc(60);
        rd32(4'd2, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL dg_slow_reject: got %h expected 0", d);
        end
        pad32[5] = 1'b1;
        wait_cyc(55);
        rd32(4'd2, d);
        n_checks++;
        if (d !== 32'h20) begin
            n_fail++; $display("FAIL dg_slow_pass: got %h expected 20", d);
        end
        pad32[5] = 1'b0;
        wait_cyc(60);
    endtask

    task automatic test_rise_irq;
        logic [31:0] d;
        do_reset();
        wr32(4'd12, 32'h1, 4'hF);
        wr32(4'd6, 32'h8, 4'hF);
        wr32(4'd11, 32'h8, 4'hF);
        pad32[3] = 1'b1;
        wait_cyc(10);
        rd32(4'd10, d);
        n_checks++;
        if (d !== 32'h8 || irq32 !== 1'b1 || intr32 !== 32'h8) begin
            n_fail++; $display("FAIL rise_int: stat %h irq %b intr %h expected 8/1/8", d, irq32, intr32);
        end
        wr32(4'd10, 32'h8, 4'hF);
        rd32(4'd10, d);
        n_checks++;
        if (d !== 32'h0 || irq32 !== 1'b0) begin
            n_fail++; $display("FAIL rise_w1c: stat %h irq %b expected 0/0", d, irq32);
        end
        pad32[3] = 1'b0;
        wait_cyc(8);
        wr32(4'd0, 32'h8, 4'hF);
        pad32[3] = 1'b1;
        wait_cyc(10);
        rd32(4'd10, d);
        n_checks++;
        if (d !== 32'h0 || irq32 !== 1'b0) begin
            n_fail++; $display("FAIL rise_dir_out: stat %h irq %b expected 0/0", d, irq32);
        end
    endtask

    task automatic test_level_and_collision;
        logic [31:0] d;
        do_reset();
        wr32(4'd12, 32'h1, 4'hF);
        wr32(4'd8, 32'h80, 4'hF);
        pad32[7] = 1'b1;
        wait_cyc(10);
        rd32(4'd10, d);
        n_checks++;
        if (d !== 32'h80) begin
            n_fail++; $display("FAIL level_set: got %h expected 80", d);
        end
        wr32(4'd10, 32'h80, 4'hF);
        rd32(4'd10, d);
        n_checks++;
        if (d !== 32'h80) begin
            n_fail++; $display("FAIL level_reassert: got %h expected 80", d);
        end
        wr32(4'd8, 32'h0, 4'hF);
        wr32(4'd10, 32'h80, 4'hF);
        rd32(4'd10, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL level_cleared: got %h expected 0", d);
        end
        // Second rise on pin 2 lands on the same edge as the W1C of STAT[2].
        wr32(4'd6, 32'h4, 4'hF);
        pad32[2] = 1'b1;
        wait_cyc(10);
        pad32[2] = 1'b0;
        wait_cyc(10);
        rd32(4'd10, d);
        n_checks++;
        if (d !== 32'h4) begin
            n_fail++; $display("FAIL collide_pre: got %h expected 4", d);
        end
        pad32[2] = 1'b1;
        repeat (6) @(posedge mclk);
        #1;
        wr32(4'd10, 32'h4, 4'hF);
        rd32(4'd10, d);
        n_checks++;
        if (d !== 32'h4) begin
            n_fail++; $display("FAIL collide_set_wins: got %h expected 4", d);
        end
        wr32(4'd10, 32'h4, 4'hF);
        rd32(4'd10, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL collide_later_clear: got %h expected 0", d);
        end
        // A clear with its byte disabled has no effect.
        pad32[2] = 1'b0;
        wait_cyc(10);
        pad32[2] = 1'b1;
        wait_cyc(10);
        wr32(4'd10, 32'h4, 4'b1110);
        rd32(4'd10, d);
        n_checks++;
        if (d !== 32'h4) begin
            n_fail++; $display("FAIL w1c_byte_disabled: got %h expected 4", d);
        end
    endtask

    task automatic test_num8;
        logic [31:0] d;
        do_reset();
        wr8(4'd0, 32'hFFFF_FFFF);
        rd8(4'd0, d);
        n_checks++;
        if (d !== 32'h0000_00FF || dir8 !== 8'hFF) begin
            n_fail++; $display("FAIL n8_dir_width: read %h dir %h expected 000000ff/ff", d, dir8);
        end
        wr8(4'd0, 32'h0);
        wr8(4'd12, 32'h1);
        wr8(4'd6, 32'h1);
        pad8[0] = 1'b1;
        wait_cyc(10);
        rd8(4'd10, d);
        n_checks++;
        if (d !== 32'h1 || intr8 !== 8'h00 || irq8 !== 1'b0) begin
            n_fail++; $display("FAIL n8_masked: stat %h intr %h irq %b expected 1/00/0", d, intr8, irq8);
        end
        b8.reg_cs = 1'b1; b8.reg_wr = 1'b1; b8.reg_addr = 4'd11;
        b8.reg_wdata = 32'h1; b8.reg_be = 4'hF;
        @(posedge mclk); #1;
        n_checks++;
        if (b8.reg_ack !== 1'b1 || intr8 !== 8'h01 || irq8 !== 1'b1) begin
            n_fail++; $display("FAIL n8_unmask_same_cycle: ack %b intr %h irq %b expected 1/01/1", b8.reg_ack, intr8, irq8);
        end
        b8.reg_cs = 1'b0;
        wait_cyc(1);
    endtask

    task automatic test_random;
        logic [31:0] m_dir, m_out, m_mask, wd, bm, d, exp, exp_stat;
        logic [3:0]  be, addr;
        int          op, pin, w;
        logic [3:0]  wr_addrs [6] = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd11};
        logic [3:0]  rd_addrs [9] = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd11, 4'd13, 4'd14, 4'd15};
        do_reset();
        m_dir = 0; m_out = 0; m_mask = 0;
        for (int it = 0; it < 30; it++) begin
            op   = $urandom_range(0, 5);
            wd   = $urandom;
            be   = 4'($urandom_range(0, 15));
            addr = wr_addrs[op];
            for (int b = 0; b < 32; b++) bm[b] = be[b / 8];
            case (addr)
                4'd0:    m_dir  = (m_dir & ~bm) | (wd & bm);
                4'd1:    m_out  = (m_out & ~bm) | (wd & bm);
                4'd3:    m_out  = m_out | (wd & bm);
                4'd4:    m_out  = m_out & ~(wd & bm);
                4'd5:    m_out  = m_out ^ (wd & bm);
                default: m_mask = (m_mask & ~bm) | (wd & bm);
            endcase
            wr32(addr, wd, be);
            addr = rd_addrs[$urandom_range(0, 8)];
            case (addr)
                4'd0:    exp = m_dir;
                4'd1:    exp = m_out;
                4'd11:   exp = m_mask;
                default: exp = 32'h0;
            endcase
            rd32(addr, d);
            n_checks++;
            if (d !== exp || out32 !== m_out || dir32 !== m_dir) begin
                n_fail++; $display("FAIL rand_reg it%0d addr %0d: read %h pad %h dir %h expected %h/%h/%h",
                                   it, addr, d, out32, dir32, exp, m_out, m_dir);
            end
        end
        // Random pulse widths: only pulses of at least DG samples raise a rise event.
        wr32(4'd0, 32'h0, 4'hF);
        wr32(4'd12, 32'h1, 4'hF);
        wr32(4'd6, 32'hFFFF_FFFF, 4'hF);
        wr32(4'd11, 32'hFFFF_FFFF, 4'hF);
        exp_stat = 0;
        for (int it = 0; it < 12; it++) begin
            pin = $urandom_range(0, 31);
            w   = $urandom_range(1, 6);
            pad32[pin] = 1'b1;
            wait_cyc(w);
            pad32[pin] = 1'b0;
            wait_cyc(12);
            if (w >= int'(DG)) exp_stat = exp_stat | (32'(1) << pin);
            rd32(4'd10, d);
            n_checks++;
            if (d !== exp_stat || irq32 !== (exp_stat != 0)) begin
                n_fail++; $display("FAIL rand_pulse it%0d pin %0d width %0d: stat %h irq %b expected %h",
                                   it, pin, w, d, irq32, exp_stat);
            end
        end
    endtask

    task automatic test_bus_protocol;
        n_checks++;
        if (bus_errors !== 0) begin
            n_fail++; $display("FAIL bus_ack: %0d accesses without ack, expected 0", bus_errors);
        end
    endtask

    initial begin
        h_reset_n = 1'b0;
        pad32 = '0;
        pad8  = '0;
        b32.reg_cs = 1'b0; b32.reg_wr = 1'b0; b32.reg_addr = '0; b32.reg_wdata = '0; b32.reg_be = '0;
        b8.reg_cs  = 1'b0; b8.reg_wr  = 1'b0; b8.reg_addr  = '0; b8.reg_wdata  = '0; b8.reg_be  = '0;
        @(posedge mclk); #1;
        test_reset();
        test_back_to_back();
        test_out_atomic();
        test_deglitch();
        test_rise_irq();
        test_level_and_collision();
        test_num8();
        test_random();
        test_bus_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
